dht11_scheduler: RTL

Sequencer for the DHT11 single-wire reader. It decides when a sensor transaction starts, from host requests or a periodic auto mode. It enforces the sensor's minimum spacing between reads, bounds each transaction with a timeout, validates the checksum, retries failures, and holds the last good humidity/temperature bytes for the rest of the design. It sits between the host/control logic and the bit-level DHT11 reader, which it drives through a one-cycle start pulse and a done/data return.

---
 rtl/dht11_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dht11_scheduler.sv
// dht11_scheduler
// Decides when a DHT11 read starts (host request or periodic auto mode),
// enforces the minimum spacing between reads, bounds each read with a
// timeout, validates the checksum, retries failures and holds the last
// good humidity/temperature bytes.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-low reset
//   req       one-shot read request (merged into a pending flag)
//   auto_en   level; read automatically every period
//   rd_start  one-cycle start pulse to the bit-level reader
//   rd_done   one-cycle pulse from the reader, rd_data valid
//   rd_data   {hum int, hum frac, temp int, temp frac, checksum}
//   hum_i, hum_f, temp_i, temp_f  last validated values
//   valid     sticky, set by the first good read
//   ack       one-cycle pulse when a transaction finishes (pass or final fail)
//   err       one-cycle pulse with ack on final failure
//   err_code  00 ok, 01 timeout, 10 checksum; updated at every ack
//   busy      high whenever the sequencer is not idle
module dht11_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        auto_en,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic [39:0] rd_data,
  output logic [7:0]  hum_i,
  output logic [7:0]  hum_f,
  output logic [7:0]  temp_i,
  output logic [7:0]  temp_f,
  output logic        valid,
  output logic        ack,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [31:0] GUARD_RESET  = 32'(PERIOD_CYCLES);
  // Reloaded in START; two fewer than the period because the START cycle and
  // the IDLE/RETRY decision cycle complete the spacing to exactly PERIOD_CYCLES.
  localparam logic [31:0] GUARD_RELOAD = 32'(PERIOD_CYCLES - 2);
  localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_RETRY
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   guard_cnt;
  logic [31:0]   tmo_cnt;
  logic [RW-1:0] retry_cnt;
  logic          pending;
  logic [39:0]   shadow;
  logic [7:0]    sum;
  logic          sum_ok;
  logic          guard_zero;
  logic          tmo_hit;
  logic          fail;
  logic          can_retry;
  logic [1:0]    cause;

  assign sum        = shadow[39:32] + shadow[31:24] + shadow[23:16] + shadow[15:8];
  assign sum_ok     = (sum == shadow[7:0]);
  assign guard_zero = (guard_cnt == '0);
  // rd_done takes priority over a timeout in the same cycle.
  assign tmo_hit    = (state == S_WAIT) && !rd_done && (tmo_cnt == TMO_LAST);
  assign fail       = tmo_hit || ((state == S_CHECK) && !sum_ok);
  assign can_retry  = (32'(retry_cnt) < MAX_RETRY);
  assign cause      = tmo_hit ? 2'b01 : 2'b10;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (guard_zero && (pending || auto_en)) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (rd_done)      state_nxt = S_CHECK;
        else if (tmo_hit) state_nxt = can_retry ? S_RETRY : S_IDLE;
      end
      S_CHECK: begin
        if (sum_ok) state_nxt = S_IDLE;
        else        state_nxt = can_retry ? S_RETRY : S_IDLE;
      end
      S_RETRY: if (guard_zero) state_nxt = S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    rd_start = (state == S_START);
    busy     = (state != S_IDLE);
  end

  // Counters, capture and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_cnt <= GUARD_RESET;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      pending   <= 1'b0;
      shadow    <= '0;
      hum_i     <= '0;
      hum_f     <= '0;
      temp_i    <= '0;
      temp_f    <= '0;
      valid     <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;

      if (state == S_START)    guard_cnt <= GUARD_RELOAD;
      else if (!guard_zero)    guard_cnt <= guard_cnt - 32'd1;

      // A request in the same cycle START is entered survives, so it is not lost.
      if (req)                       pending <= 1'b1;
      else if (state_nxt == S_START) pending <= 1'b0;

      if (state == S_START)
        tmo_cnt <= '0;
      else if ((state == S_WAIT) && !rd_done && !tmo_hit)
        tmo_cnt <= tmo_cnt + 32'd1;

      if ((state == S_WAIT) && rd_done)
        shadow <= rd_data;

      if ((state == S_CHECK) && sum_ok) begin
        hum_i     <= shadow[39:32];
        hum_f     <= shadow[31:24];
        temp_i    <= shadow[23:16];
        temp_f    <= shadow[15:8];
        valid     <= 1'b1;
        err_code  <= 2'b00;
        ack       <= 1'b1;
        retry_cnt <= '0;
      end else if (fail) begin
        if (can_retry) begin
          retry_cnt <= retry_cnt + RW'(1);
        end else begin
          ack       <= 1'b1;
          err       <= 1'b1;
          err_code  <= cause;
          retry_cnt <= '0;
        end
      end
    end
  end

endmodule
